// File: rtl/mem_initiator.sv
// mem_initiator: initiator side of a single-outstanding memory request/response
// protocol. Takes one core request at a time, rejects misaligned addresses
// locally, forwards the rest to memory and returns read data or write
// completion. A per-request timeout aborts hung transactions. Any response
// that memory still owes afterwards is absorbed silently.
module mem_initiator #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 64,
  parameter int CHECK_ALIGN   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  // core request channel
  input  logic                     c_valid,
  output logic                     c_ready,
  input  logic                     c_cmd,
  input  logic [ADDRESS_WIDTH-1:0] c_address,
  input  logic [DATA_WIDTH-1:0]    c_data,
  // core response channel
  output logic                     c_res_valid,
  input  logic                     c_res_ready,
  output logic [DATA_WIDTH-1:0]    c_res_data,
  output logic                     c_res_err,
  // memory request channel
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_cmd,
  output logic [ADDRESS_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0]    m_data,
  // memory response channel
  input  logic                     m_res_valid,
  output logic                     m_res_ready,
  input  logic [DATA_WIDTH-1:0]    m_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // A zero TIMEOUT disables the timeout, but the counter still needs one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;

  // Byte-offset bits that must be zero for a word-aligned access.
  localparam int ALIGN_BITS = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
    ADDRESS_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [1:0]               state_q, state_d;
  logic                     cmd_q, cmd_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    res_data_q, res_data_d;
  logic                     res_err_q, res_err_d;
  logic                     stale_q, stale_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [CNT_W-1:0]         cnt_inc;
  logic                     timeout_hit;
  logic                     misaligned;
  logic                     core_hs;

  // The counter saturates at the limit. The timeout fires on the edge where it
  // reaches the limit, so a request spends at most TIMEOUT cycles in REQ+WAIT.
  assign cnt_inc     = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_inc == CNT_LIMIT);
  assign misaligned  = (CHECK_ALIGN != 0) && ((c_address & ALIGN_MASK) != '0);

  // Gate c_ready with reset so it can only rise once reset is released.
  assign c_ready     = reset && (state_q == ST_IDLE) && !stale_q;
  assign core_hs     = c_valid && c_ready;

  assign m_valid     = (state_q == ST_REQ);
  assign m_cmd       = cmd_q;
  assign m_address   = addr_q;
  assign m_data      = wdata_q;
  // A stale response must drain even outside WAIT, because memory holds off
  // new requests until it has delivered it.
  assign m_res_ready = (state_q == ST_WAIT) || stale_q;
  assign c_res_valid = (state_q == ST_RESP);
  assign c_res_data  = res_data_q;
  assign c_res_err   = res_err_q;

  // Next-state logic: request latching, memory handshakes, timeout and stale drain.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    stale_d    = stale_q;
    cnt_d      = cnt_q;

    // The first response seen while stale belongs to an aborted read.
    if (stale_q && m_res_valid) begin
      stale_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (core_hs) begin
          cmd_d   = c_cmd;
          addr_d  = c_address;
          wdata_d = c_data;
          if (misaligned) begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        // An acceptance on the timeout edge still counts as accepted.
        if (m_ready) begin
          if (cmd_q) begin
            res_data_d = '0;
            res_err_d  = 1'b0;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (timeout_hit) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A response on the timeout edge wins over the timeout.
        if (m_res_valid) begin
          res_data_d = m_rdata;
          res_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (timeout_hit) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          stale_d    = 1'b1;
          state_d    = ST_RESP;
        end
      end
      default: begin
        if (c_res_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      stale_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      stale_q    <= stale_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: table-driven and randomized checks of mem_initiator with a
// small timeout. The bench acts as the core and as the memory, and it compares
// each response with a transaction-level model.
`timescale 1ns/1ps
module tb_mem_initiator;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_valid, c_ready, c_cmd;
  logic [AW-1:0] c_address;
  logic [DW-1:0] c_data;
  logic          c_res_valid, c_res_ready, c_res_err;
  logic [DW-1:0] c_res_data;
  logic          m_valid, m_ready, m_cmd;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data;
  logic          m_res_valid, m_res_ready;
  logic [DW-1:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          a;        // cycles of m_valid before memory raises m_ready
    int          r;        // WAIT cycles before memory raises m_res_valid
    logic [31:0] rdata;
    int          h;        // cycles the core holds c_res_ready low
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;  // cycles from core accept to c_res_valid
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  mem_initiator #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .CHECK_ALIGN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .c_valid(c_valid), .c_ready(c_ready), .c_cmd(c_cmd),
    .c_address(c_address), .c_data(c_data),
    .c_res_valid(c_res_valid), .c_res_ready(c_res_ready),
    .c_res_data(c_res_data), .c_res_err(c_res_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_cmd(m_cmd),
    .m_address(m_address), .m_data(m_data),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready), .m_rdata(m_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: response and latency derived from the timing rules.
  function automatic void model(input logic cmd, input logic [31:0] addr, input int a,
                                input int r, input logic [31:0] rd,
                                output logic err, output logic [31:0] data, output int lat);
    int abort_idx;
    if (addr[1:0] != 2'b00) begin
      err = 1'b1; data = '0; lat = 1;
    end else if (a > TO - 1) begin
      err = 1'b1; data = '0; lat = TO + 1;          // never accepted by memory
    end else if (cmd) begin
      err = 1'b0; data = '0; lat = a + 2;
    end else if ((a + 1 + r <= TO - 1) || (r == 0)) begin
      err = 1'b0; data = rd; lat = a + r + 3;
    end else begin
      abort_idx = (TO - 1 > a + 1) ? TO - 1 : a + 1;
      err = 1'b1; data = '0; lat = abort_idx + 2;
    end
  endfunction

  // Play one transaction as core and memory. Protocol rules are checked inside,
  // and the observed response is returned for comparison with the model.
  task automatic run_txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata,
                         input int a, input int r, input logic [31:0] rd, input int h,
                         output logic got_err, output logic [31:0] got_data, output int got_lat);
    int  cyc, mv_idx, deliver_at, hold, guard, phase, exp_mv;
    bit  owed, owed_now, first_post, pay_ok, mrr_ok, hold_ok, post_ok, aligned;
    got_err = 1'b0; got_data = '0; got_lat = -1;
    aligned = (addr[1:0] == 2'b00);
    guard = 0;
    while (c_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    check("c_ready_before_request", c_ready, 1);
    c_valid = 1'b1; c_cmd = cmd; c_address = addr; c_data = wdata;
    step();
    c_valid = 1'b0; c_cmd = 1'($urandom); c_address = $urandom; c_data = $urandom;
    check("m_valid_one_cycle_after_accept", m_valid, aligned);
    cyc = 1; mv_idx = 0; hold = 0; phase = 1; deliver_at = 0;
    owed = 0; first_post = 1; pay_ok = 1; mrr_ok = 1; hold_ok = 1; post_ok = 1;
    while (cyc < 120) begin
      owed_now = owed;
      if (m_res_ready && !owed_now) mrr_ok = 0;
      if (phase == 2) begin
        if (first_post) begin
          check("c_ready_after_response", c_ready, !owed_now);
          first_post = 0;
        end else if (c_ready !== !owed_now) begin
          post_ok = 0;
        end
        if (c_res_valid) post_ok = 0;
        if (!owed_now) break;
      end
      // memory request side
      if (m_valid) begin
        if (m_cmd !== cmd || m_address !== addr || m_data !== wdata) pay_ok = 0;
        m_ready = (mv_idx >= a);
        mv_idx++;
        if (m_ready && !cmd) begin
          owed = 1;
          deliver_at = cyc + 1 + r;
        end
      end else begin
        m_ready = 1'b0;
      end
      // memory response side; a late response is delivered regardless
      if (owed_now && cyc >= deliver_at) begin
        m_res_valid = 1'b1;
        m_rdata = rd;
        if (m_res_ready) owed = 0;
      end else begin
        m_res_valid = 1'b0;
        m_rdata = $urandom;
      end
      // core response side
      if (phase == 1) begin
        if (c_res_valid) begin
          if (got_lat < 0) begin
            got_lat = cyc; got_err = c_res_err; got_data = c_res_data;
          end else if (c_res_err !== got_err || c_res_data !== got_data) begin
            hold_ok = 0;
          end
          if (c_ready !== 1'b0) hold_ok = 0;
          c_res_ready = (hold >= h);
          hold++;
          if (c_res_ready) phase = 2;
        end else begin
          if (got_lat >= 0) hold_ok = 0;
          c_res_ready = 1'b0;
        end
      end else begin
        c_res_ready = 1'b0;
      end
      step();
      cyc++;
    end
    m_ready = 1'b0; m_res_valid = 1'b0; c_res_ready = 1'b0;
    check("transaction_completes_in_bound", (phase == 2) && !owed, 1);
    exp_mv = !aligned ? 0 : ((a <= TO - 1) ? a + 1 : TO);
    check("m_valid_cycle_count", mv_idx, exp_mv);
    check("m_payload_stable", pay_ok, 1);
    check("m_res_ready_only_when_owed", mrr_ok, 1);
    check("response_held_until_taken", hold_ok, 1);
    check("c_ready_stale_drain", post_ok, 1);
  endtask

  task automatic compare_txn(input string tag, input int idx, input logic cmd,
                             input logic [31:0] addr, input logic exp_err,
                             input logic [31:0] exp_data, input int exp_lat,
                             input logic got_err, input logic [31:0] got_data, input int got_lat);
    $display("%s %0d cmd=%0d addr=0x%0h err=%0d data=0x%0h lat=%0d (exp err=%0d data=0x%0h lat=%0d)",
             tag, idx, cmd, addr, got_err, got_data, got_lat, exp_err, exp_data, exp_lat);
    check({tag, "_err"}, got_err, exp_err);
    check({tag, "_data"}, got_data, exp_data);
    check({tag, "_latency"}, got_lat, exp_lat);
  endtask

  initial begin
    logic        g_err, e_err, cmd;
    logic [31:0] g_data, e_data, addr, wd, rd;
    int          g_lat, e_lat, a, r, h;
    bit          quiet_ok;

    //           cmd  addr          wdata         a   r   rdata          h  err  data           lat
    vecs[0]  = '{1'b0, 32'h10, 32'h0,        0,  0,  32'hDEADBEEF,  0, 1'b0, 32'hDEADBEEF,  3};
    vecs[1]  = '{1'b1, 32'h20, 32'h12345678, 3,  0,  32'h0,         0, 1'b0, 32'h0,         5};
    vecs[2]  = '{1'b0, 32'h13, 32'h0,        0,  0,  32'hAAAA5555,  0, 1'b1, 32'h0,         1};
    vecs[3]  = '{1'b0, 32'h40, 32'h0,        0,  20, 32'h77778888,  0, 1'b1, 32'h0,         9};
    vecs[4]  = '{1'b0, 32'h44, 32'h0,        1,  2,  32'hCAFEF00D,  5, 1'b0, 32'hCAFEF00D,  6};
    vecs[5]  = '{1'b1, 32'h08, 32'h9999AAAA, 10, 0,  32'h0,         0, 1'b1, 32'h0,         9};
    vecs[6]  = '{1'b0, 32'h50, 32'h0,        7,  0,  32'h11112222,  0, 1'b0, 32'h11112222, 10};
    vecs[7]  = '{1'b0, 32'h54, 32'h0,        6,  1,  32'hBBBBCCCC,  1, 1'b1, 32'h0,         9};
    vecs[8]  = '{1'b0, 32'h58, 32'h0,        5,  1,  32'h33334444,  0, 1'b0, 32'h33334444,  9};
    vecs[9]  = '{1'b1, 32'h04, 32'hFEEDFACE, 7,  0,  32'h0,         0, 1'b0, 32'h0,         9};
    vecs[10] = '{1'b1, 32'h02, 32'h01020304, 0,  0,  32'h0,         0, 1'b1, 32'h0,         1};
    vecs[11] = '{1'b0, 32'h5C, 32'h0,        2,  0,  32'h55556666,  2, 1'b0, 32'h55556666,  5};

    reset = 1'b0;
    c_valid = 1'b0; c_cmd = 1'b0; c_address = '0; c_data = '0; c_res_ready = 1'b0;
    m_ready = 1'b0; m_res_valid = 1'b0; m_rdata = '0;
    step();
    step();
    check("reset_c_ready", c_ready, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_c_res_valid", c_res_valid, 0);
    check("reset_m_res_ready", m_res_ready, 0);
    check("reset_c_res_data", c_res_data, 0);
    check("reset_c_res_err", c_res_err, 0);
    check("reset_m_cmd_addr_data", {m_cmd, m_address, m_data}, 0);
    reset = 1'b1;
    step();
    check("c_ready_after_reset_release", c_ready, 1);

    foreach (vecs[i]) begin
      run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].a, vecs[i].r,
              vecs[i].rdata, vecs[i].h, g_err, g_data, g_lat);
      compare_txn("vec", i, vecs[i].cmd, vecs[i].addr, vecs[i].exp_err,
                  vecs[i].exp_data, vecs[i].exp_lat, g_err, g_data, g_lat);
    end

    // Reset while waiting for a read response abandons it without a core response.
    c_valid = 1'b1; c_cmd = 1'b0; c_address = 32'h30; c_data = '0;
    step();
    c_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    step();
    check("wait_state_m_res_ready", m_res_ready, 1);
    reset = 1'b0;
    #1;
    check("async_reset_m_res_ready", m_res_ready, 0);
    check("async_reset_c_ready", c_ready, 0);
    check("async_reset_c_res_valid", c_res_valid, 0);
    check("async_reset_m_valid", m_valid, 0);
    check("async_reset_m_address", m_address, 0);
    check("async_reset_c_res_data", c_res_data, 0);
    step();
    step();
    check("c_ready_held_in_reset", c_ready, 0);
    reset = 1'b1;
    quiet_ok = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (c_res_valid !== 1'b0 || c_ready !== 1'b1) quiet_ok = 0;
    end
    check("no_response_after_reset", quiet_ok, 1);
    run_txn(1'b0, 32'h0, 32'h0, 0, 1, 32'h0BADF00D, 1, g_err, g_data, g_lat);
    compare_txn("post_reset", 0, 1'b0, 32'h0, 1'b0, 32'h0BADF00D, 4, g_err, g_data, g_lat);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      cmd  = 1'($urandom_range(0, 1));
      addr = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      rd = $urandom;
      a  = $urandom_range(0, 10);
      r  = $urandom_range(0, 10);
      h  = $urandom_range(0, 3);
      model(cmd, addr, a, r, rd, e_err, e_data, e_lat);
      run_txn(cmd, addr, wd, a, r, rd, h, g_err, g_data, g_lat);
      compare_txn("rand", i, cmd, addr, e_err, e_data, e_lat, g_err, g_data, g_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator side of the single-outstanding memory request/response protocol; sits between the core load/store path and the memory model.
- Accepts one core request at a time and drives the memory request channel (valid/ready) and the response channel (res_valid/res_ready).
- Returns read data, or write completion, to the core. Adds an alignment check and a per-request timeout.

Parameters:
- TIMEOUT, 64, max cycles spent in REQ plus WAIT before the request is aborted with an error; 0 disables the timeout.
- CHECK_ALIGN, 1, when 1 a core address not aligned to DATA_WIDTH/8 bytes is rejected with an error and never reaches memory.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- c_valid  in  1  core request valid
- c_ready  out  1  initiator can accept a core request
- c_cmd  in  1  0 = read, 1 = write (same encoding as the memory command)
- c_address  in  ADDRESS_WIDTH  byte address
- c_data  in  DATA_WIDTH  write data
- c_res_valid  out  1  core response valid
- c_res_ready  in  1  core accepts the response
- c_res_data  out  DATA_WIDTH  read data; 0 for writes and errors
- c_res_err  out  1  1 = misaligned address or timeout
- m_valid  out  1  memory request valid
- m_ready  in  1  memory can accept a request
- m_cmd  out  1  memory command
- m_address  out  ADDRESS_WIDTH  memory byte address
- m_data  out  DATA_WIDTH  memory write data
- m_res_valid  in  1  memory response valid
- m_res_ready  out  1  initiator accepts the memory response
- m_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- All handshakes complete at a posedge where valid and ready are both 1.
- Reset (reset = 0, asynchronous):
  - state = IDLE, stale = 0, timeout counter = 0.
  - All out valids = 0, c_res_data = 0, c_res_err = 0; m_cmd, m_address and m_data = 0.
  - c_ready goes to 1 only after reset deasserts.
  - Reset mid-transaction abandons it; the core gets no response.
- Widths: timeout counter is $clog2(TIMEOUT+1) bits and saturates.
- IDLE:
  - c_ready = 1 when stale = 0, otherwise 0.
  - On the core handshake, latch cmd, address and data. Misaligned with CHECK_ALIGN = 1 -> RESP with err = 1; otherwise -> REQ with counter = 0.
- REQ:
  - m_valid = 1, with m_cmd, m_address and m_data taken from the latched values; they stay stable until accepted.
  - On m_valid & m_ready, m_valid drops the next cycle. A write goes to RESP with data = 0 and err = 0. A read goes to WAIT.
- WAIT:
  - m_res_ready = 1.
  - On m_res_valid, capture m_rdata into c_res_data, set err = 0 and go to RESP.
- Timeout:
  - The counter increments each cycle in REQ and WAIT.
  - When the counter equals TIMEOUT and TIMEOUT > 0, go to RESP with err = 1 and data = 0, and deassert m_valid.
  - If the timeout occurs in WAIT, set stale = 1.
  - A response arriving in the same cycle as the timeout wins: normal completion, no error.
- Stale response:
  - While stale = 1, m_res_ready = 1 in every state.
  - The first m_res_valid seen is discarded and clears stale.
  - c_ready stays 0 while stale = 1, because memory withholds m_ready until its response is taken.
- RESP:
  - c_res_valid = 1; data and err are held stable until c_res_ready, then -> IDLE.
  - c_ready = 0 in RESP, so there is no new request on the same edge (one cycle of bubble).
- Latency:
  - Core accept to m_valid = 1 cycle.
  - Memory response to c_res_valid = 1 cycle.
  - Misaligned request to error response = 1 cycle.
- Concurrency: only one request is outstanding; no pipelining.
- c_valid while c_ready = 0 is ignored; the core must hold the request.

Test Plan:
- Aligned read, addr 0x10, memory returns 0xDEADBEEF -> m_valid 1 cycle after accept, m_address = 0x10, m_cmd = 0; c_res_data = 0xDEADBEEF, c_res_err = 0, 1 cycle after m_res_valid.
- Write, addr 0x20, data 0x12345678, m_ready held 0 for 3 cycles -> m_valid and payload stable across all 3 cycles; completion with data 0 and err 0 the cycle after acceptance; m_res_ready never 1.
- Misaligned read, addr 0x13, DATA_WIDTH = 32 -> m_valid never asserts; c_res_err = 1 one cycle after accept.
- TIMEOUT = 8, memory never responds to a read -> c_res_err = 1 after 8 cycles in REQ/WAIT. A late response is absorbed with m_res_ready = 1 and no c_res_valid; c_ready = 0 until absorbed, then a following read completes normally.
- c_res_ready held 0 for 5 cycles -> c_res_valid, data and err are held and c_ready stays 0; IDLE is reached 1 cycle after c_res_ready.
- Reset asserted in WAIT -> outputs clear asynchronously, no core response; after release a read to 0x0 completes normally.
